// File: rtl/number_sprite_renderer_pkg.sv
// rtl/number_sprite_renderer_pkg.sv - shared constants and helpers for the digit sprite renderer
package number_render_pkg;

    localparam int BCD_W        = 4;
    localparam int GLYPH_COUNT  = 10;
    localparam int COLOUR_W     = 12;
    localparam int VGA_ACTIVE_W = 640;
    localparam int VGA_ACTIVE_H = 480;
    // One spare bit over the 10-bit screen coordinate so a negative offset wraps far out of range.
    localparam int COORD_W      = 11;

    function automatic int glyph_stride(input int glyph_w, input int glyph_h);
        return glyph_w * glyph_h;
    endfunction

endpackage

// File: rtl/number_sprite_renderer_if.sv
// rtl/number_sprite_renderer_if.sv - pixel stream, sync and glyph memory signals of the renderer
interface number_sprite_renderer_if #(
    parameter int ROM_ADDR_WIDTH = 16
);
    import number_render_pkg::*;

    logic [9:0]                ADDRH;
    logic [9:0]                ADDRV;
    logic                      DISP_EN_IN;
    logic                      HS_IN;
    logic                      VS_IN;
    logic [COLOUR_W-1:0]       COLOUR_OUT;
    logic                      DISP_EN_OUT;
    logic                      HS_OUT;
    logic                      VS_OUT;
    logic [ROM_ADDR_WIDTH-1:0] ROM_ADDR;
    logic                      ROM_DATA;

    // master: sync generator plus glyph memory side; slave: the renderer
    modport master (
        output ADDRH, ADDRV, DISP_EN_IN, HS_IN, VS_IN, ROM_DATA,
        input  COLOUR_OUT, DISP_EN_OUT, HS_OUT, VS_OUT, ROM_ADDR
    );

    modport slave (
        input  ADDRH, ADDRV, DISP_EN_IN, HS_IN, VS_IN, ROM_DATA,
        output COLOUR_OUT, DISP_EN_OUT, HS_OUT, VS_OUT, ROM_ADDR
    );

endinterface

// File: rtl/number_sprite_renderer_digit_locator.sv
// rtl/number_sprite_renderer_digit_locator.sv - maps a box-relative pixel to digit index, column and in-box flag
module digit_locator
    import number_render_pkg::*;
#(
    parameter int GLYPH_W    = 62,
    parameter int GLYPH_H    = 87,
    parameter int NUM_DIGITS = 4,
    parameter int K_W        = 2
) (
    input  logic [COORD_W-1:0] dx,
    input  logic [COORD_W-1:0] dy,
    input  logic               disp_en,
    output logic [K_W-1:0]     k,
    output logic [COORD_W-1:0] col,
    output logic               in_box
);

    // Every digit boundary is compared in parallel; the highest boundary passed wins.
    always_comb begin
        k      = '0;
        col    = dx;
        for (int i = 1; i < NUM_DIGITS; i++) begin
            if (dx >= COORD_W'(i * GLYPH_W)) begin
                k   = K_W'(i);
                col = dx - COORD_W'(i * GLYPH_W);
            end
        end
        in_box = disp_en
              && (dx < COORD_W'(NUM_DIGITS * GLYPH_W))
              && (dy < COORD_W'(GLYPH_H));
    end

endmodule

// File: rtl/number_sprite_renderer.sv
// rtl/number_sprite_renderer.sv - renders a row of BCD digit glyphs; NUMBER_RENDER_LEADING_ZERO_BLANK_EN blanks leading zeros
module number_sprite_renderer
    import number_render_pkg::*;
#(
    parameter int GLYPH_W        = 62,
    parameter int GLYPH_H        = 87,
    parameter int NUM_DIGITS     = 4,
    parameter int ORIGIN_X       = 160,
    parameter int ORIGIN_Y       = 196,
    parameter int ROM_ADDR_WIDTH = 16
) (
    input  logic                          CLK,
    input  logic                          RESET,
    number_sprite_renderer_if.slave       vid,
    input  logic                          FRAME_START,
    input  logic [BCD_W*NUM_DIGITS-1:0]   VALUE_IN,
    input  logic [COLOUR_W-1:0]           FG_COLOUR,
    input  logic [COLOUR_W-1:0]           BG_COLOUR
);

    localparam int K_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int STRIDE = glyph_stride(GLYPH_W, GLYPH_H);

    logic [BCD_W*NUM_DIGITS-1:0] disp_value;
    logic [COORD_W-1:0]          dx;
    logic [COORD_W-1:0]          dy;
    logic [K_W-1:0]              loc_k;
    logic [COORD_W-1:0]          loc_col;
    logic                        loc_in_box;
    logic [BCD_W-1:0]            glyph;
    logic                        blank_hit;
    logic                        valid_glyph;
    logic [ROM_ADDR_WIDTH-1:0]   addr_next;

    logic [ROM_ADDR_WIDTH-1:0]   rom_addr_q;
    logic                        valid_glyph_d;
    logic [1:0]                  de_d;
    logic [1:0]                  hs_d;
    logic [1:0]                  vs_d;
    logic [COLOUR_W-1:0]         colour_q;

    // Offsets wrap to large values when the pixel lies left of or above the box.
    assign dx = COORD_W'(vid.ADDRH) - COORD_W'(ORIGIN_X);
    assign dy = COORD_W'(vid.ADDRV) - COORD_W'(ORIGIN_Y);

    digit_locator #(
        .GLYPH_W    (GLYPH_W),
        .GLYPH_H    (GLYPH_H),
        .NUM_DIGITS (NUM_DIGITS),
        .K_W        (K_W)
    ) u_digit_locator (
        .dx      (dx),
        .dy      (dy),
        .disp_en (vid.DISP_EN_IN),
        .k       (loc_k),
        .col     (loc_col),
        .in_box  (loc_in_box)
    );

    // Digit 0 sits in the most significant nibble.
    always_comb begin
        glyph = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (loc_k == K_W'(i)) begin
                glyph = disp_value[BCD_W*(NUM_DIGITS-1-i) +: BCD_W];
            end
        end
    end

`ifdef NUMBER_RENDER_LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] blank_mask;
    logic [NUM_DIGITS-1:0] blank_mask_next;
    logic                  lead_zero;

    // A digit is blanked while it and everything to its left is zero; the last digit always shows.
    always_comb begin
        blank_mask_next = '0;
        lead_zero       = 1'b1;
        for (int i = 0; i < NUM_DIGITS - 1; i++) begin
            lead_zero          = lead_zero && (VALUE_IN[BCD_W*(NUM_DIGITS-1-i) +: BCD_W] == '0);
            blank_mask_next[i] = lead_zero;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            blank_mask <= NUM_DIGITS'((1 << (NUM_DIGITS - 1)) - 1);
        end else if (FRAME_START) begin
            blank_mask <= blank_mask_next;
        end
    end

    always_comb begin
        blank_hit = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (loc_k == K_W'(i)) begin
                blank_hit = blank_mask[i];
            end
        end
    end
`else
    assign blank_hit = 1'b0;
`endif

    assign valid_glyph = loc_in_box && (glyph <= BCD_W'(GLYPH_COUNT - 1)) && !blank_hit;

    assign addr_next = ROM_ADDR_WIDTH'(glyph) * ROM_ADDR_WIDTH'(STRIDE)
                     + ROM_ADDR_WIDTH'(dy)    * ROM_ADDR_WIDTH'(GLYPH_W)
                     + ROM_ADDR_WIDTH'(loc_col);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            disp_value    <= '0;
            rom_addr_q    <= '0;
            valid_glyph_d <= 1'b0;
            de_d          <= 2'b00;
            hs_d          <= 2'b11;
            vs_d          <= 2'b11;
            colour_q      <= '0;
        end else begin
            if (FRAME_START) begin
                disp_value <= VALUE_IN;
            end
            // Holding the address when idle keeps the memory port quiet outside the glyphs.
            if (valid_glyph) begin
                rom_addr_q <= addr_next;
            end
            valid_glyph_d <= valid_glyph;
            de_d          <= {de_d[0], vid.DISP_EN_IN};
            hs_d          <= {hs_d[0], vid.HS_IN};
            vs_d          <= {vs_d[0], vid.VS_IN};
            if (!de_d[0]) begin
                colour_q <= '0;
            end else if (valid_glyph_d && vid.ROM_DATA) begin
                colour_q <= FG_COLOUR;
            end else begin
                colour_q <= BG_COLOUR;
            end
        end
    end

    assign vid.ROM_ADDR    = rom_addr_q;
    assign vid.COLOUR_OUT  = colour_q;
    assign vid.DISP_EN_OUT = de_d[1];
    assign vid.HS_OUT      = hs_d[1];
    assign vid.VS_OUT      = vs_d[1];

endmodule

// File: tb/tb_number_sprite_renderer.sv
// tb/tb_number_sprite_renderer.sv - self-checking bench for number_sprite_renderer against a pixel-level model
module tb_number_sprite_renderer;

    localparam int GLYPH_W    = 62;
    localparam int GLYPH_H    = 87;
    localparam int NUM_DIGITS = 4;
    localparam int ORIGIN_X   = 160;
    localparam int ORIGIN_Y   = 196;
    localparam int AW         = 16;

    typedef struct {
        logic [AW-1:0] addr;
        bit            valid;
        int            cls;    // 0 black, 1 foreground, 2 background
        bit            de;
        bit            hs;
        bit            vs;
    } exp_t;

    logic        CLK;
    logic        RESET;
    logic        FRAME_START;
    logic [15:0] VALUE_IN;
    logic [11:0] FG_COLOUR;
    logic [11:0] BG_COLOUR;

    number_sprite_renderer_if #(.ROM_ADDR_WIDTH(AW)) vif ();

    number_sprite_renderer #(
        .GLYPH_W        (GLYPH_W),
        .GLYPH_H        (GLYPH_H),
        .NUM_DIGITS     (NUM_DIGITS),
        .ORIGIN_X       (ORIGIN_X),
        .ORIGIN_Y       (ORIGIN_Y),
        .ROM_ADDR_WIDTH (AW)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .vid         (vif),
        .FRAME_START (FRAME_START),
        .VALUE_IN    (VALUE_IN),
        .FG_COLOUR   (FG_COLOUR),
        .BG_COLOUR   (BG_COLOUR)
    );

    bit rom_img [0:65535];

    always_comb vif.ROM_DATA = rom_img[vif.ROM_ADDR];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int            n_assert = 0;
    int            n_fail   = 0;
    logic [15:0]   m_value;
    logic [AW-1:0] m_addr;
    exp_t          p1;
    exp_t          p2;
    exp_t          flush_e;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [11:0] cls_colour(input int cls);
        if (cls == 0) return 12'h000;
        if (cls == 1) return FG_COLOUR;
        return BG_COLOUR;
    endfunction

    // Pixel-level rendering rule, written from screen geometry with division and modulo.
    function automatic exp_t model(input int x, input int y, input bit de, input logic [15:0] v);
        exp_t e;
        int   dx, dy, k, col, g;
        bit   blank;
        e.addr  = '0;
        e.valid = 1'b0;
        e.de    = de;
        e.hs    = 1'b1;
        e.vs    = 1'b1;
        e.cls   = de ? 2 : 0;
        dx = x - ORIGIN_X;
        dy = y - ORIGIN_Y;
        if (de && dx >= 0 && dx < NUM_DIGITS * GLYPH_W && dy >= 0 && dy < GLYPH_H) begin
            k     = dx / GLYPH_W;
            col   = dx % GLYPH_W;
            g     = int'((v >> (4 * (NUM_DIGITS - 1 - k))) & 16'hF);
            blank = 1'b0;
`ifdef NUMBER_RENDER_LEADING_ZERO_BLANK_EN
            if (k < NUM_DIGITS - 1 && (v >> (4 * (NUM_DIGITS - 1 - k))) == 16'h0) blank = 1'b1;
`endif
            if (g <= 9 && !blank) begin
                e.valid = 1'b1;
                e.addr  = AW'(g * GLYPH_W * GLYPH_H + dy * GLYPH_W + col);
                e.cls   = rom_img[e.addr] ? 1 : 2;
            end
        end
        return e;
    endfunction

    task automatic tick(input int x, input int y, input bit de, input bit hs, input bit vs,
                        input bit fs, input bit rst);
        exp_t e;
        RESET          = rst;
        vif.ADDRH      = 10'(x);
        vif.ADDRV      = 10'(y);
        vif.DISP_EN_IN = de;
        vif.HS_IN      = hs;
        vif.VS_IN      = vs;
        FRAME_START    = fs;
        e    = model(x, y, de, m_value);
        e.hs = hs;
        e.vs = vs;
        @(posedge CLK);
        if (rst) begin
            m_value = '0;
            m_addr  = '0;
            p1      = flush_e;
            p2      = flush_e;
        end else begin
            if (fs) m_value = VALUE_IN;
            if (e.valid) m_addr = e.addr;
            p2 = p1;
            p1 = e;
        end
        @(negedge CLK);
        chk("rom_addr", 32'(vif.ROM_ADDR), 32'(m_addr));
        chk("colour", 32'(vif.COLOUR_OUT), 32'(cls_colour(p2.cls)));
        chk("disp_en_out", 32'(vif.DISP_EN_OUT), 32'(p2.de));
        chk("hs_out", 32'(vif.HS_OUT), 32'(p2.hs));
        chk("vs_out", 32'(vif.VS_OUT), 32'(p2.vs));
    endtask

    task automatic px(input int x, input int y);
        tick(x, y, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) rom_img[i] = 1'($urandom);
        flush_e = '{addr: '0, valid: 1'b0, cls: 0, de: 1'b0, hs: 1'b1, vs: 1'b1};
        m_value   = '0;
        m_addr    = '0;
        p1        = flush_e;
        p2        = flush_e;
        VALUE_IN  = 16'h1234;
        FG_COLOUR = 12'hF80;
        BG_COLOUR = 12'h013;

        tick(0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        tick(0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("reset_colour", 32'(vif.COLOUR_OUT), 32'h0);
        chk("reset_hs", 32'(vif.HS_OUT), 32'h1);

        // Latch 0x1234 and walk the box corners and edges.
        tick(0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        px(160, 196);
        chk("addr_160_196", 32'(vif.ROM_ADDR), 32'd5394);
        px(222, 196);
        chk("addr_222_196", 32'(vif.ROM_ADDR), 32'd10788);
        px(408, 196);
        chk("addr_held_408", 32'(vif.ROM_ADDR), 32'd10788);
        px(407, 282);
        px(159, 200);
        px(160, 195);
        px(200, 283);
        px(221, 282);
        px(345, 250);
        px(346, 250);
        px(400, 250);

        // Mid-frame value change only applies after the next frame strobe.
        VALUE_IN = 16'h9999;
        px(160, 196);
        chk("old_value_kept", 32'(vif.ROM_ADDR), 32'd5394);
        tick(160, 196, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("strobe_pixel_old", 32'(vif.ROM_ADDR), 32'd5394);
        px(160, 196);
        chk("new_value_used", 32'(vif.ROM_ADDR), 32'd48546);

        // Non-BCD nibble in digit 2, then blanked video inside the box.
        VALUE_IN = 16'h12B4;
        tick(0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        for (int x = 280; x < 350; x++) px(x, 200);
        for (int x = 160; x < 170; x++) tick(x, 220, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        px(300, 200);
        px(300, 200);

        // Reset in the middle of a line.
        for (int x = 170; x < 180; x++) px(x, 230);
        tick(180, 230, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("midline_reset_colour", 32'(vif.COLOUR_OUT), 32'h0);
        for (int x = 181; x < 190; x++) px(x, 230);

        // Leading-zero values.
        VALUE_IN = 16'h0042;
        tick(0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        for (int x = 160; x < 408; x += 7) px(x, 240);
        VALUE_IN = 16'h0000;
        tick(0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        for (int x = 160; x < 408; x += 7) px(x, 241);

        // Random pixels, syncs, strobes and values around the box.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 40) == 0) VALUE_IN = 16'($urandom);
            if ($urandom_range(0, 200) == 0) FG_COLOUR = 12'($urandom);
            tick(int'($urandom_range(140, 430)), int'($urandom_range(180, 300)),
                 $urandom_range(0, 7) != 0, 1'($urandom), 1'($urandom),
                 $urandom_range(0, 63) == 0, $urandom_range(0, 499) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
